// File: rtl/vlog_acc_pipe.sv
// Multi-channel registered adder/accumulator with one-cycle latency and valid/ready
// handshakes; overflow either wraps or saturates to all-ones per the SATURATE parameter.
module vlog_acc_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int SATURATE = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_ACC  = 2'd1,
        OP_CLR  = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    localparam logic [CW:0] CHAN_LIM = CHANNELS[CW:0];

    // Carry bits above WIDTH flag overflow; the result is either the wrapped low
    // bits or all-ones when saturating.
    function automatic logic [WIDTH-1:0] wrap_or_sat(input logic [WIDTH+1:0] s);
        if ((|s[WIDTH+1:WIDTH]) && (SATURATE != 0)) begin
            return {WIDTH{1'b1}};
        end
        return s[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] acc [CHANNELS];

    logic             vld_p1;
    logic [CW-1:0]    chan_p1;
    logic [WIDTH-1:0] sum_p1;
    logic             ovf_p1;

    logic             accept_p0;
    logic             chan_ok_p0;
    logic [WIDTH-1:0] acc_rd_p0;
    logic [WIDTH-1:0] addend_p0;
    logic [WIDTH+1:0] full_p0;
    logic [WIDTH-1:0] res_p0;
    logic             ovf_p0;
    logic             wr_en_p0;
    logic [WIDTH-1:0] wr_val_p0;
    op_e              op_p0;

    // Stage p0: request decode and arithmetic
    assign in_ready   = rst || !vld_p1 || out_ready;
    assign accept_p0  = in_valid && in_ready;
    assign chan_ok_p0 = ({1'b0, in_chan} < CHAN_LIM);
    assign op_p0      = op_e'(in_op);

    always_comb begin
        acc_rd_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (in_chan == CW'(i)) begin
                acc_rd_p0 = acc[i];
            end
        end
    end

    assign addend_p0 = (op_p0 == OP_ACC) ? acc_rd_p0 : '0;
    assign full_p0   = {2'b00, in_a} + {2'b00, in_b} + {2'b00, addend_p0};

    always_comb begin
        res_p0    = '0;
        ovf_p0    = 1'b0;
        wr_en_p0  = 1'b0;
        wr_val_p0 = '0;
        if (!chan_ok_p0) begin
            ovf_p0 = 1'b1;
        end else begin
            unique case (op_p0)
                OP_ADD: begin
                    res_p0 = wrap_or_sat(full_p0);
                    ovf_p0 = |full_p0[WIDTH+1:WIDTH];
                end
                OP_ACC: begin
                    res_p0    = wrap_or_sat(full_p0);
                    ovf_p0    = |full_p0[WIDTH+1:WIDTH];
                    wr_en_p0  = 1'b1;
                    wr_val_p0 = wrap_or_sat(full_p0);
                end
                OP_CLR: begin
                    wr_en_p0 = 1'b1;
                end
                OP_LOAD: begin
                    res_p0    = in_a;
                    wr_en_p0  = 1'b1;
                    wr_val_p0 = in_a;
                end
                default: ;
            endcase
        end
    end

    // Stage p1: output register and accumulator update
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            chan_p1 <= '0;
            sum_p1  <= '0;
            ovf_p1  <= 1'b0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            chan_p1 <= in_chan;
            sum_p1  <= res_p0;
            ovf_p1  <= ovf_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Invalid channels never match an index, so they leave every accumulator alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) begin
                acc[i] <= '0;
            end else if (accept_p0 && wr_en_p0 && (in_chan == CW'(i))) begin
                acc[i] <= wr_val_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_chan  = chan_p1;
    assign out_sum   = sum_p1;
    assign out_ovf   = ovf_p1;

endmodule
